pulse_stretch: RTL

Output-side counterpart to the switch debouncer. It turns single-cycle event ticks into long, visibly separated high levels for board LEDs and probe pins, and sits between core/debug logic and the board outputs in the board-test build. Each accepted tick produces one high pulse of exactly 2^N cycles followed by a guaranteed low gap of 2^M cycles. With the queue feature compiled in, ticks that arrive while a pulse or gap is in progress are counted and replayed in order.

---
 rtl/pulse_stretch.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - stretches single-cycle ticks into 2^N-cycle pulses separated by 2^M-cycle gaps
// Optional pending-tick queue enabled by defining PULSE_STRETCH_QUEUE_EN.
module pulse_stretch #(
    parameter int N  = 21,
    parameter int M  = 21,
    parameter int QW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick_in,
    output logic          level,
    output logic          busy,
    output logic [QW-1:0] pending,
    output logic          drop
);

    localparam int CW = (N > M) ? N : M;
    localparam logic [CW-1:0] ON_LOAD  = CW'((64'd1 << N) - 64'd1);
    localparam logic [CW-1:0] GAP_LOAD = CW'((64'd1 << M) - 64'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, busy_q, drop_q;
    logic          drop_d;
    logic          enq;
    logic          deq;
    logic          have_pending;
    logic          cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // enq: a tick that cannot start a pulse right now; deq: a queued tick replayed
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        enq     = 1'b0;
        deq     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_in) begin
                    state_d = ST_ON;
                    cnt_d   = ON_LOAD;
                end
            end
            ST_ON: begin
                enq = tick_in;
                if (cnt_zero) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    if (have_pending) begin
                        state_d = ST_ON;
                        cnt_d   = ON_LOAD;
                        deq     = 1'b1;
                        enq     = tick_in;
                    end else if (tick_in) begin
                        state_d = ST_ON;
                        cnt_d   = ON_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    enq   = tick_in;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef PULSE_STRETCH_QUEUE_EN
    logic [QW-1:0] pend_q, pend_d;

    assign have_pending = (pend_q != '0);

    // A replay paired with a new tick leaves the count unchanged and never drops
    always_comb begin
        pend_d = pend_q;
        drop_d = 1'b0;
        case ({enq, deq})
            2'b10: begin
                if (pend_q == '1) drop_d = 1'b1;
                else              pend_d = pend_q + 1'b1;
            end
            2'b01:   pend_d = pend_q - 1'b1;
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign pending = pend_q;
`else
    assign have_pending = 1'b0;
    assign pending      = '0;

    always_comb begin
        drop_d = enq | deq;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= (state_d == ST_ON);
            busy_q  <= (state_d != ST_IDLE);
            drop_q  <= drop_d;
        end
    end

    assign level = level_q;
    assign busy  = busy_q;
    assign drop  = drop_q;

endmodule
